// File: rtl/tjmono_ab_scheduler_pkg.sv
// Shared definitions for the TJ-Monopix A/B readout scheduler:
// FSM state encoding, MODE codes and flavor constants.
package tjmono_ab_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_GRANT   = 2'd2
    } state_e;

    localparam logic [1:0] MODE_A_ONLY = 2'b00;
    localparam logic [1:0] MODE_B_ONLY = 2'b01;
    localparam logic [1:0] MODE_RR     = 2'b10;
    localparam logic [1:0] MODE_RR_ALT = 2'b11;

    localparam logic FLAV_A = 1'b0;
    localparam logic FLAV_B = 1'b1;

    // Returns {allow_b, allow_a}; the spare code 11 behaves as round-robin.
    function automatic logic [1:0] mode_allow(input logic [1:0] mode);
        logic [1:0] allow;
        case (mode)
            MODE_A_ONLY: allow = 2'b01;
            MODE_B_ONLY: allow = 2'b10;
            default:     allow = 2'b11;
        endcase
        return allow;
    endfunction

endpackage

// File: rtl/tjmono_ab_scheduler_tok_sync.sv
// Two-flop synchronizer for one raw chip token into the CLK40 domain.
module tjmono_tok_sync (
    input  logic CLK,
    input  logic RST_N,
    input  logic D,
    output logic Q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= D;
            sync_q <= meta_q;
        end
    end

    assign Q = sync_q;

endmodule

// File: rtl/tjmono_ab_scheduler.sv
// Round-robin scheduler sharing one readout receiver between flavors A and B.
// Optional statistics counters are built only when TJMONO_AB_STATS_EN is defined.
//
//   state   | meaning
//   IDLE    | no grant; pick the next flavor from synchronized tokens and MODE
//   HOLDOFF | SEL just toggled; token and strobes blocked while the mux settles
//   GRANT   | receiver owned by SEL until RX_FREEZE falls or the grant times out
module tjmono_ab_scheduler
    import tjmono_ab_scheduler_pkg::*;
#(
    parameter int HOLDOFF   = 4,
    parameter int MAX_GRANT = 1024,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 ENABLE,
    input  logic [1:0]           MODE,
    input  logic                 TOK_A,
    input  logic                 TOK_B,
    input  logic                 RX_READ,
    input  logic                 RX_FREEZE,
    output logic                 TOK_OUT,
    output logic                 SEL,
    output logic                 READ_A,
    output logic                 READ_B,
    output logic                 FREEZE_A,
    output logic                 FREEZE_B,
    output logic                 BUSY,
    output logic [CNT_WIDTH-1:0] SWITCH_CNT,
    output logic [CNT_WIDTH-1:0] TIMEOUT_CNT
);

    localparam int GW = $clog2(MAX_GRANT + 1);

    logic          t_a;
    logic          t_b;
    state_e        state_q;
    logic          sel_q;
    logic          pri_q;
    logic          tok_out_q;
    logic [7:0]    hold_q;
    logic [GW-1:0] grant_q;
    logic          frz_seen_q;

    tjmono_tok_sync u_sync_a (.CLK(CLK), .RST_N(RST_N), .D(TOK_A), .Q(t_a));
    tjmono_tok_sync u_sync_b (.CLK(CLK), .RST_N(RST_N), .D(TOK_B), .Q(t_b));

    logic [1:0] allow;
    logic       cand_a;
    logic       cand_b;
    logic       has_cand;
    logic       want;
    logic       do_switch;
    logic       frz_done;
    logic       grant_to;
    logic       grant_exit;
    logic       in_grant;

    assign allow      = mode_allow(MODE);
    assign cand_a     = t_a & allow[0];
    assign cand_b     = t_b & allow[1];
    assign has_cand   = cand_a | cand_b;
    assign want       = (cand_a & cand_b) ? pri_q : (cand_b ? FLAV_B : FLAV_A);
    assign do_switch  = (state_q == ST_IDLE) & ENABLE & has_cand & (want != sel_q);
    // The timeout is armed only until the first freeze; a freeze is never cut.
    assign frz_done   = frz_seen_q & ~RX_FREEZE;
    assign grant_to   = ~frz_seen_q & ~RX_FREEZE & (grant_q == GW'(MAX_GRANT - 1));
    assign in_grant   = (state_q == ST_GRANT);
    assign grant_exit = in_grant & (frz_done | grant_to);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            sel_q      <= FLAV_A;
            pri_q      <= FLAV_A;
            tok_out_q  <= 1'b0;
            hold_q     <= 8'd0;
            grant_q    <= '0;
            frz_seen_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tok_out_q <= 1'b0;
                    if (ENABLE && has_cand) begin
                        if (do_switch) begin
                            sel_q   <= want;
                            hold_q  <= 8'(HOLDOFF);
                            state_q <= ST_HOLDOFF;
                        end else begin
                            grant_q    <= '0;
                            frz_seen_q <= 1'b0;
                            state_q    <= ST_GRANT;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    tok_out_q <= 1'b0;
                    hold_q    <= hold_q - 8'd1;
                    if (hold_q == 8'd1) begin
                        grant_q    <= '0;
                        frz_seen_q <= 1'b0;
                        state_q    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (grant_exit) begin
                        tok_out_q <= 1'b0;
                        pri_q     <= ~sel_q;
                        state_q   <= ST_IDLE;
                    end else begin
                        tok_out_q <= sel_q ? t_b : t_a;
                        if (!frz_seen_q) grant_q <= grant_q + GW'(1);
                        if (RX_FREEZE) frz_seen_q <= 1'b1;
                    end
                end
                default: begin
                    tok_out_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign TOK_OUT  = tok_out_q;
    assign SEL      = sel_q;
    assign BUSY     = (state_q != ST_IDLE);
    assign READ_A   = in_grant & (sel_q == FLAV_A) & RX_READ;
    assign READ_B   = in_grant & (sel_q == FLAV_B) & RX_READ;
    assign FREEZE_A = in_grant & (sel_q == FLAV_A) & RX_FREEZE;
    assign FREEZE_B = in_grant & (sel_q == FLAV_B) & RX_FREEZE;

`ifdef TJMONO_AB_STATS_EN
    logic [CNT_WIDTH-1:0] switch_cnt_q;
    logic [CNT_WIDTH-1:0] timeout_cnt_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            switch_cnt_q  <= '0;
            timeout_cnt_q <= '0;
        end else begin
            if (do_switch && (switch_cnt_q != '1)) switch_cnt_q <= switch_cnt_q + 1'b1;
            if (in_grant && grant_to && (timeout_cnt_q != '1)) timeout_cnt_q <= timeout_cnt_q + 1'b1;
        end
    end

    assign SWITCH_CNT  = switch_cnt_q;
    assign TIMEOUT_CNT = timeout_cnt_q;
`else
    assign SWITCH_CNT  = '0;
    assign TIMEOUT_CNT = '0;
`endif

endmodule

// File: tb/tb_tjmono_ab_scheduler.sv
// Randomized scoreboard bench for tjmono_ab_scheduler; grants are predicted
// from the scheduling rules and checked by an independent monitor.
module tb_tjmono_ab_scheduler;

    localparam int HOLDOFF   = 4;
    localparam int MAX_GRANT = 1024;
    localparam int CW        = 16;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          ENABLE = 1'b1;
    logic [1:0]    MODE = 2'b10;
    logic          TOK_A = 1'b0, TOK_B = 1'b0;
    logic          RX_READ = 1'b0, RX_FREEZE = 1'b0;
    logic          TOK_OUT, SEL, READ_A, READ_B, FREEZE_A, FREEZE_B, BUSY;
    logic [CW-1:0] SWITCH_CNT, TIMEOUT_CNT;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic flav;
        int   cyc;
        int   sw;
        int   to;
    } exp_t;
    exp_t exp_q[$];

    logic act = 1'b0;
    logic aflav = 1'b0;
    logic tok_prev = 1'b0;

    logic sel_m = 1'b0, pri_m = 1'b0;
    int   sw_m = 0, to_m = 0;

    tjmono_ab_scheduler #(.HOLDOFF(HOLDOFF), .MAX_GRANT(MAX_GRANT), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .MODE(MODE),
        .TOK_A(TOK_A), .TOK_B(TOK_B), .RX_READ(RX_READ), .RX_FREEZE(RX_FREEZE),
        .TOK_OUT(TOK_OUT), .SEL(SEL), .READ_A(READ_A), .READ_B(READ_B),
        .FREEZE_A(FREEZE_A), .FREEZE_B(FREEZE_B), .BUSY(BUSY),
        .SWITCH_CNT(SWITCH_CNT), .TIMEOUT_CNT(TIMEOUT_CNT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic int cnt_exp(input int v);
`ifdef TJMONO_AB_STATS_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: pops one expectation per TOK_OUT rise, checks strobe routing during grants.
    always @(negedge CLK) begin : monitor
        exp_t e;
        if (TOK_OUT && !tok_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("grant_sel", SEL, e.flav);
                check("grant_latency", cyc, e.cyc);
                check("switch_cnt", SWITCH_CNT, e.sw);
                check("timeout_cnt", TIMEOUT_CNT, e.to);
            end
        end
        tok_prev = TOK_OUT;
        if (act)
            check("strobes", {READ_A, READ_B, FREEZE_A, FREEZE_B},
                  {~aflav & RX_READ, aflav & RX_READ, ~aflav & RX_FREEZE, aflav & RX_FREEZE});
    end

    // kind: 0 = normal freeze cycle, 1 = no freeze (timeout), 2 = reset during freeze
    task automatic run_txn(input logic [1:0] mode, input logic en, input logic ta, input logic tb_,
                           input int kind, input int dly, input int flen);
        logic ca, cb, has, flav, sw;
        int   lat, t0, trise, n;
        bit   got;
        ca   = ta & (mode != 2'b01);
        cb   = tb_ & (mode != 2'b00);
        has  = en & (ca | cb);
        flav = (ca & cb) ? pri_m : cb;
        MODE = mode;
        ENABLE = en;
        tick();
        TOK_A = ta;
        TOK_B = tb_;
        t0 = cyc;
        if (!has) begin
            repeat (12) tick();
            check("idle_hold", {BUSY, TOK_OUT, SEL}, {1'b0, 1'b0, sel_m});
            TOK_A = 1'b0;
            TOK_B = 1'b0;
            repeat (4) tick();
            ENABLE = 1'b1;
            return;
        end
        sw  = (flav != sel_m);
        lat = 4 + (sw ? HOLDOFF : 0);
        if (sw) sw_m++;
        exp_q.push_back('{flav, t0 + lat, cnt_exp(sw_m), cnt_exp(to_m)});
        sel_m = flav;
        pri_m = ~flav;
        trise = t0 + lat;

        got = 0;
        for (n = 0; n < 60 && !got; n++) begin
            @(negedge CLK);
            got = TOK_OUT;
        end
        if (!got) begin
            check("grant_wait", 0, 1);
            TOK_A = 1'b0;
            TOK_B = 1'b0;
            repeat (MAX_GRANT + 40) tick();
            exp_q.delete();
            return;
        end
        act = 1'b1;
        aflav = flav;
        tick();

        if (kind == 0) begin
            repeat (dly) tick();
            RX_READ = 1'b1;
            tick();
            RX_READ = 1'b0;
            RX_FREEZE = 1'b1;
            TOK_A = 1'b0;
            TOK_B = 1'b0;
            repeat (flen) tick();
            RX_FREEZE = 1'b0;
            @(negedge CLK);
            check("busy_before_exit", BUSY, 1);
            @(negedge CLK);
            check("busy_after_exit", BUSY, 0);
        end else if (kind == 1) begin
            TOK_A = 1'b0;
            TOK_B = 1'b0;
            got = 0;
            for (n = 0; n < MAX_GRANT + 50 && !got; n++) begin
                @(negedge CLK);
                got = !BUSY;
            end
            if (!got) check("timeout_wait", 0, 1);
            else check("timeout_release_cycle", cyc, trise + MAX_GRANT - 1);
            to_m++;
            check("timeout_cnt_after", TIMEOUT_CNT, cnt_exp(to_m));
        end else begin
            RX_FREEZE = 1'b1;
            TOK_A = 1'b0;
            TOK_B = 1'b0;
            tick();
            tick();
            act = 1'b0;
            #2;
            RST_N = 1'b0;
            #1;
            check("reset_strobes", {READ_A, READ_B, FREEZE_A, FREEZE_B}, 4'b0000);
            check("reset_state", {BUSY, TOK_OUT, SEL}, 3'b000);
            check("reset_cnts", {SWITCH_CNT, TIMEOUT_CNT}, 0);
            RX_FREEZE = 1'b0;
            repeat (2) tick();
            RST_N = 1'b1;
            sel_m = 1'b0;
            pri_m = 1'b0;
            sw_m = 0;
            to_m = 0;
            tick();
            check("post_reset", {BUSY, TOK_OUT, SEL, SWITCH_CNT, TIMEOUT_CNT}, 0);
        end
        act = 1'b0;
        repeat (3) tick();
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_outputs", {BUSY, TOK_OUT, SEL, READ_A, READ_B, FREEZE_A, FREEZE_B}, 0);
        check("reset_counters", {SWITCH_CNT, TIMEOUT_CNT}, 0);
        tick();
        RST_N = 1'b1;
        repeat (3) tick();

        run_txn(2'b10, 1, 1, 1, 0, 1, 10);
        run_txn(2'b10, 1, 0, 1, 0, 0, 3);
        run_txn(2'b00, 1, 0, 1, 0, 0, 3);
        run_txn(2'b10, 1, 1, 0, 1, 0, 0);
        run_txn(2'b11, 1, 1, 1, 0, 2, 4);
        run_txn(2'b10, 0, 1, 1, 0, 0, 3);

        for (int i = 0; i < 40; i++) begin
            run_txn(2'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 19) == 0) ? 1 : 0,
                    $urandom_range(0, 3),
                    $urandom_range(3, 12));
        end

        run_txn(2'b10, 1, 0, 1, 2, 0, 0);
        run_txn(2'b10, 1, 1, 1, 0, 0, 5);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
